// File: rtl/grid_pkg.sv
// Shared constants, scan state encoding and row extraction for the LED grid scan driver.
package grid_pkg;

    localparam int GRID_N = 8;
    localparam int GRID_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Row r of a generation is the byte grid[8r+7:8r]; bit c of that byte is column c.
    function automatic logic [GRID_N-1:0] row_slice(input logic [GRID_W-1:0] grid_word,
                                                    input logic [2:0]        row);
        return grid_word[{row, 3'b000} +: GRID_N];
    endfunction

endpackage

// File: rtl/grid_dbuf.sv
// Pending/display double buffer: captures one waiting generation and hands it to the
// display side only at a frame-start swap, so a frame never mixes two generations.
module grid_dbuf
    import grid_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    output logic              grid_ready,
    input  logic              swap,
    output logic [GRID_W-1:0] display_next
);

    logic [GRID_W-1:0] pending_r;
    logic [GRID_W-1:0] display_r;
    logic              full_r;
    logic              accept_s;
    logic              swap_s;

    // Accept only into an empty pending slot; a swap only moves a waiting generation.
    assign grid_ready = ~full_r;
    assign accept_s   = grid_valid & ~full_r;
    assign swap_s     = swap & full_r;

    // Value the display buffer takes at the coming edge, so the scan side can register
    // the first row of a freshly swapped frame without a cycle of lag.
    always_comb begin
        display_next = display_r;
        if (swap_s) begin
            display_next = pending_r;
        end else begin
            display_next = display_r;
        end
    end

    // Buffer registers; swap and accept are mutually exclusive because one needs a full slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {GRID_W{1'b0}};
            display_r <= {GRID_W{1'b0}};
            full_r    <= 1'b0;
        end else begin
            display_r <= display_next;
            if (swap_s) begin
                full_r <= 1'b0;
            end else if (accept_s) begin
                full_r    <= 1'b1;
                pending_r <= grid;
            end
        end
    end

endmodule

// File: rtl/grid_scan_driver.sv
// Row-scanning driver for an 8x8 LED matrix fed by the life grid bus. Each row gets
// BLANK dark cycles followed by DWELL lit cycles; enable is only looked at frame ends.
module grid_scan_driver
    import grid_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    output logic              grid_ready,
    input  logic              enable,
    output logic [GRID_N-1:0] row_sel,
    output logic [GRID_N-1:0] col_data,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [15:0]  DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0]  BLANK_LAST = 16'(BLANK - 1);
    localparam scan_state_t  ROW_START  = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    scan_state_t       state_r;
    scan_state_t       state_s;
    logic [2:0]        row_r;
    logic [2:0]        row_s;
    logic [15:0]       cnt_r;
    logic [15:0]       cnt_s;
    logic              swap_s;
    logic [GRID_W-1:0] display_next_s;

    grid_dbuf u_dbuf (
        .clk          (clk),
        .reset        (reset),
        .grid         (grid),
        .grid_valid   (grid_valid),
        .grid_ready   (grid_ready),
        .swap         (swap_s),
        .display_next (display_next_s)
    );

    // Scan state, row index and dwell/blank counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            row_r   <= 3'd0;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; swap is requested on every frame start (IDLE exit or row-7 wrap).
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        cnt_s   = cnt_r;
        swap_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ROW_START;
                    row_s   = 3'd0;
                    cnt_s   = 16'd0;
                    swap_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_SHOW;
                    cnt_s   = 16'd0;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_SHOW: begin
                if (cnt_r == DWELL_LAST) begin
                    cnt_s = 16'd0;
                    row_s = row_r + 3'd1;
                    if (row_r == 3'd7) begin
                        if (enable) begin
                            state_s = ROW_START;
                            swap_s  = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ROW_START;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                row_s   = 3'd0;
                cnt_s   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel    <= {GRID_N{1'b0}};
            col_data   <= {GRID_N{1'b0}};
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy       <= (state_s != ST_IDLE);
            frame_done <= (state_s == ST_SHOW) && (row_s == 3'd7) && (cnt_s == DWELL_LAST);
            if (state_s == ST_SHOW) begin
                row_sel  <= 8'd1 << row_s;
                col_data <= row_slice(display_next_s, row_s);
            end else begin
                row_sel  <= {GRID_N{1'b0}};
                col_data <= {GRID_N{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Scoreboard bench: a frame-position reference model predicts every output cycle,
// a negedge monitor compares. A second instance with BLANK=0 checks back-to-back rows.
module tb_grid_scan_driver;

    localparam int DW  = 4;
    localparam int BL  = 1;
    localparam int PER = DW + BL;
    localparam int FL  = 8 * PER;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] grid = 64'd0;
    logic        grid_valid = 1'b0;
    logic        enable = 1'b0;
    logic        grid_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic        busy;

    logic [63:0] grid_b = 64'd0;
    logic        grid_valid_b = 1'b0;
    logic        enable_b = 1'b0;
    logic        grid_ready_b;
    logic [7:0]  row_sel_b;
    logic [7:0]  col_data_b;
    logic        frame_done_b;
    logic        busy_b;

    always #5 clk = ~clk;

    grid_scan_driver #(.DWELL(DW), .BLANK(BL)) dut (
        .clk(clk), .reset(reset), .grid(grid), .grid_valid(grid_valid),
        .grid_ready(grid_ready), .enable(enable), .row_sel(row_sel),
        .col_data(col_data), .frame_done(frame_done), .busy(busy)
    );

    grid_scan_driver #(.DWELL(4), .BLANK(0)) dut_b (
        .clk(clk), .reset(reset), .grid(grid_b), .grid_valid(grid_valid_b),
        .grid_ready(grid_ready_b), .enable(enable_b), .row_sel(row_sel_b),
        .col_data(col_data_b), .frame_done(frame_done_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fd;
        logic       bz;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: frame position counter plus a one-deep pending slot.
    bit          m_active = 1'b0;
    int          m_pos = 0;
    bit          m_full = 1'b0;
    logic [63:0] m_pend = 64'd0;
    logic [63:0] m_disp = 64'd0;

    task automatic model_step();
        bit   fs;
        exp_t e;
        int   r;
        int   w;
        if (reset) begin
            m_active = 1'b0; m_pos = 0; m_full = 1'b0;
            m_pend = 64'd0; m_disp = 64'd0;
        end else begin
            fs = 1'b0;
            if (!m_active) begin
                if (enable) begin fs = 1'b1; m_active = 1'b1; m_pos = 0; end
            end else if (m_pos == FL - 1) begin
                if (enable) begin fs = 1'b1; m_pos = 0; end
                else begin m_active = 1'b0; m_pos = 0; end
            end else begin
                m_pos = m_pos + 1;
            end
            if (fs && m_full) begin
                m_disp = m_pend; m_full = 1'b0;
            end else if (grid_valid && !m_full) begin
                m_pend = grid; m_full = 1'b1;
            end
        end
        e = '0;
        e.rdy = !m_full;
        if (m_active) begin
            r = m_pos / PER;
            w = m_pos % PER;
            e.bz = 1'b1;
            if (w >= BL) begin
                e.rs = 8'(1 << r);
                e.cd = m_disp[8*r +: 8];
            end
            e.fd = (r == 7) && (w == PER - 1);
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            cyc = cyc + 1;
        end
    end

    // Monitor: every cycle the DUT presents a new output word; compare against the model.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {row_sel, col_data, frame_done, busy, grid_ready};
                checks = checks + 1;
                if (got !== e) begin
                    errors = errors + 1;
                    $display("FAIL scoreboard cyc=%0d got rs=%h cd=%h fd=%b busy=%b rdy=%b want rs=%h cd=%h fd=%b busy=%b rdy=%b",
                             cyc, got.rs, got.cd, got.fd, got.bz, got.rdy, e.rs, e.cd, e.fd, e.bz, e.rdy);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold grid_valid until the DUT is ready (bounded), then drop it after the accepting edge.
    task automatic offer(input logic [63:0] g);
        bit ok;
        ok = 1'b0;
        grid = g;
        grid_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (grid_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        grid_valid = 1'b0;
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL accept_timeout grid=%h got ready=%b want 1", g, grid_ready);
        end
    endtask

    task automatic wait_pos(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_active && m_pos == p) hit = 1'b1;
            else tick(1);
        end
        checks = checks + 1;
        if (!hit) begin
            errors = errors + 1;
            $display("FAIL wait_pos got pos=%0d want %0d", m_pos, p);
        end
    endtask

    initial begin
        int  n;
        int  dark;
        int  seqerr;
        bit  seen;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);

        // X pattern, then FF arrives during row 3, then a third grid waits behind it.
        offer(64'h8142241818244281);
        enable = 1'b1;
        wait_pos(16);
        offer(64'hFFFFFFFFFFFFFFFF);
        offer({$urandom, $urandom});
        tick(2 * FL);

        // Drop enable in row 2: the frame completes, then IDLE.
        wait_pos(11);
        enable = 1'b0;
        tick(FL);

        // Random traffic with occasional enable changes.
        enable = 1'b1;
        for (int i = 0; i < 800; i++) begin
            grid = {$urandom, $urandom};
            grid_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick(1);
        end
        grid_valid = 1'b0;

        // Reset during row 5 SHOW, then rescan with cleared buffers.
        enable = 1'b1;
        wait_pos(27);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(FL + 10);
        enable = 1'b0;

        // BLANK=0 instance: rows back-to-back, 32-cycle frame.
        grid_b = 64'h0102040810204080;
        grid_valid_b = 1'b1;
        enable_b = 1'b1;
        tick(1);
        grid_valid_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(1);
            if (frame_done_b) seen = 1'b1;
        end
        n = 0; dark = 0; seqerr = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(1);
            n = n + 1;
            if (row_sel_b == 8'd0 || col_data_b == 8'd0) dark = dark + 1;
            if (row_sel_b != 8'(1 << ((n - 1) / 4))) seqerr = seqerr + 1;
            if (frame_done_b) seen = 1'b1;
        end
        checks = checks + 1;
        if (n != 32) begin
            errors = errors + 1;
            $display("FAIL b_frame_len got %0d want 32", n);
        end
        checks = checks + 1;
        if (dark != 0) begin
            errors = errors + 1;
            $display("FAIL b_dark_cycles got %0d want 0", dark);
        end
        checks = checks + 1;
        if (seqerr != 0) begin
            errors = errors + 1;
            $display("FAIL b_row_sequence got %0d wrong rows want 0", seqerr);
        end
        enable_b = 1'b0;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
